// File: rtl/trap_seq_if.sv
// Trap access channel between the trap sequencer and the CSR block.
// The CSR block answers csr_rdata combinationally from csr_addr.
interface trap_seq_if;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;

  modport master (
    output csr_we,
    output csr_addr,
    output csr_wdata,
    input  csr_rdata
  );

  modport slave (
    input  csr_we,
    input  csr_addr,
    input  csr_wdata,
    output csr_rdata
  );
endinterface

// File: rtl/trap_seq.sv
// Trap sequencer: on an exception, interrupt or mret from idex it holds the pipeline,
// updates mepc/mcause/mtval/mstatus through the trap CSR channel and issues one redirect.
module trap_seq #(
  parameter bit VECTORED_EN = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ecall_i,
  input  logic              ebreak_i,
  input  logic              illegal_i,
  input  logic              mret_i,
  input  logic [31:0]       inst_i,
  input  logic [31:0]       pc_i,
  input  logic [31:0]       pc_next_i,
  input  logic              hx_valid_i,
  input  logic              ex_trap_i,
  input  logic              tcmp_trap_i,
  input  logic              soft_trap_i,
  input  logic              mstatus_mie_i,
  input  logic              idex_csr_we_i,
  trap_seq_if.master        csr,
  output logic              hold_o,
  output logic              jump_o,
  output logic [31:0]       jump_addr_o
);

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
  localparam logic [31:0] CAUSE_EBREAK  = 32'd3;
  localparam logic [31:0] CAUSE_ECALL   = 32'd11;
  localparam logic [31:0] CAUSE_EXT     = 32'h8000_000B;
  localparam logic [31:0] CAUSE_TIMER   = 32'h8000_0007;
  localparam logic [31:0] CAUSE_SOFT    = 32'h8000_0003;

  typedef enum logic [3:0] {
    S_IDLE,
    S_W_EPC,
    S_W_CAUSE,
    S_W_TVAL,
    S_W_STAT,
    S_JMP,
    S_R_STAT,
    S_M_W_STAT,
    S_JMP_EPC
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [31:0] cause_q;
  logic [31:0] epc_q;
  logic [31:0] tval_q;
  logic        is_int_q;
  logic        mpie_q;

  logic        exc_req;
  logic        irq_req;
  logic        take_trap;
  logic        take_mret;
  logic        event_detect;
  logic [31:0] cause_d;
  logic [31:0] epc_d;
  logic [31:0] tval_d;
  logic [31:0] vec_off;

  logic        we;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic        jump;
  logic [31:0] jump_addr;

  // Priority encode the idex event; interrupts resume at the next pc, exceptions re-execute.
  always_comb begin
    cause_d = '0;
    epc_d   = pc_i;
    tval_d  = '0;
    exc_req = illegal_i | ebreak_i | ecall_i;
    irq_req = mstatus_mie_i & (ex_trap_i | tcmp_trap_i | soft_trap_i);
    if (illegal_i) begin
      cause_d = CAUSE_ILLEGAL;
      tval_d  = inst_i;
    end else if (ebreak_i) begin
      cause_d = CAUSE_EBREAK;
      tval_d  = pc_i;
    end else if (ecall_i) begin
      cause_d = CAUSE_ECALL;
    end else if (mstatus_mie_i && ex_trap_i) begin
      cause_d = CAUSE_EXT;
      epc_d   = pc_next_i;
    end else if (mstatus_mie_i && tcmp_trap_i) begin
      cause_d = CAUSE_TIMER;
      epc_d   = pc_next_i;
    end else if (mstatus_mie_i && soft_trap_i) begin
      cause_d = CAUSE_SOFT;
      epc_d   = pc_next_i;
    end
  end

  assign take_trap    = (state == S_IDLE) && hx_valid_i && (exc_req || irq_req);
  assign take_mret    = (state == S_IDLE) && hx_valid_i && mret_i && !exc_req && !irq_req;
  assign event_detect = take_trap | take_mret;

  // Vector offset applies only to interrupts when mtvec selects vectored mode.
  assign vec_off = (VECTORED_EN && (csr.csr_rdata[1:0] == 2'b01) && is_int_q) ?
                   {cause_q[29:0], 2'b00} : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cause_q  <= '0;
      epc_q    <= '0;
      tval_q   <= '0;
      is_int_q <= 1'b0;
      mpie_q   <= 1'b0;
    end else begin
      if (take_trap) begin
        cause_q  <= cause_d;
        epc_q    <= epc_d;
        tval_q   <= tval_d;
        is_int_q <= !exc_req;
      end
      if (state == S_R_STAT) begin
        mpie_q <= csr.csr_rdata[7];
      end
    end
  end

  // A write state only advances once idex is not claiming the CSR port this cycle.
  always_comb begin
    state_nxt = state;
    we        = 1'b0;
    addr      = '0;
    wdata     = '0;
    jump      = 1'b0;
    jump_addr = '0;
    unique case (state)
      S_IDLE: begin
        if (take_trap) begin
          state_nxt = S_W_EPC;
        end else if (take_mret) begin
          state_nxt = S_R_STAT;
        end
      end
      S_W_EPC: begin
        we    = 1'b1;
        addr  = CSR_MEPC;
        wdata = epc_q;
        if (!idex_csr_we_i) state_nxt = S_W_CAUSE;
      end
      S_W_CAUSE: begin
        we    = 1'b1;
        addr  = CSR_MCAUSE;
        wdata = cause_q;
        if (!idex_csr_we_i) state_nxt = S_W_TVAL;
      end
      S_W_TVAL: begin
        we    = 1'b1;
        addr  = CSR_MTVAL;
        wdata = tval_q;
        if (!idex_csr_we_i) state_nxt = S_W_STAT;
      end
      S_W_STAT: begin
        we    = 1'b1;
        addr  = CSR_MSTATUS;
        wdata = {24'h0, csr.csr_rdata[3], 3'h0, 1'b0, 3'h0};
        if (!idex_csr_we_i) state_nxt = S_JMP;
      end
      S_JMP: begin
        addr      = CSR_MTVEC;
        jump      = 1'b1;
        jump_addr = {csr.csr_rdata[31:2], 2'b00} + vec_off;
        state_nxt = S_IDLE;
      end
      S_R_STAT: begin
        addr      = CSR_MSTATUS;
        state_nxt = S_M_W_STAT;
      end
      S_M_W_STAT: begin
        we    = 1'b1;
        addr  = CSR_MSTATUS;
        wdata = {24'h0, 1'b1, 3'h0, mpie_q, 3'h0};
        if (!idex_csr_we_i) state_nxt = S_JMP_EPC;
      end
      S_JMP_EPC: begin
        addr      = CSR_MEPC;
        jump      = 1'b1;
        jump_addr = csr.csr_rdata;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign csr.csr_we    = we;
  assign csr.csr_addr  = addr;
  assign csr.csr_wdata = wdata;
  assign jump_o        = jump;
  assign jump_addr_o   = jump_addr;
  assign hold_o        = event_detect | (state != S_IDLE);

endmodule

// File: tb/tb_trap_seq.sv
// Scoreboard bench for trap_seq: a small CSR model answers the trap channel,
// directed events push expected CSR writes/jumps and a monitor pops and compares them.
`timescale 1ns/1ps
module tb_trap_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ecall_i, ebreak_i, illegal_i, mret_i;
  logic [31:0] inst_i, pc_i, pc_next_i;
  logic        hx_valid_i, ex_trap_i, tcmp_trap_i, soft_trap_i;
  logic        mstatus_mie_i, idex_csr_we_i;
  logic        hold_o, jump_o;
  logic [31:0] jump_addr_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    string       name;
    bit          is_jump;
    logic [11:0] addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  trap_seq_if csr_if ();

  trap_seq #(.VECTORED_EN(1'b1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ecall_i       (ecall_i),
    .ebreak_i      (ebreak_i),
    .illegal_i     (illegal_i),
    .mret_i        (mret_i),
    .inst_i        (inst_i),
    .pc_i          (pc_i),
    .pc_next_i     (pc_next_i),
    .hx_valid_i    (hx_valid_i),
    .ex_trap_i     (ex_trap_i),
    .tcmp_trap_i   (tcmp_trap_i),
    .soft_trap_i   (soft_trap_i),
    .mstatus_mie_i (mstatus_mie_i),
    .idex_csr_we_i (idex_csr_we_i),
    .csr           (csr_if.master),
    .hold_o        (hold_o),
    .jump_o        (jump_o),
    .jump_addr_o   (jump_addr_o)
  );

  // CSR block model: idex writes win, so trap writes are dropped while idex_csr_we_i is high.
  logic [31:0] mstatus_r, mtvec_r, mepc_r, mcause_r, mtval_r;
  logic        cfg_we;
  logic [11:0] cfg_addr;
  logic [31:0] cfg_data;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;

  always_comb begin
    csr_if.csr_rdata = 32'h0;
    case (csr_if.csr_addr)
      12'h300: csr_if.csr_rdata = mstatus_r;
      12'h305: csr_if.csr_rdata = mtvec_r;
      12'h341: csr_if.csr_rdata = mepc_r;
      12'h342: csr_if.csr_rdata = mcause_r;
      12'h343: csr_if.csr_rdata = mtval_r;
      default: csr_if.csr_rdata = 32'h0;
    endcase
  end

  assign mstatus_mie_i = mstatus_r[3];
  assign wr_en   = cfg_we | (csr_if.csr_we & ~idex_csr_we_i);
  assign wr_addr = cfg_we ? cfg_addr : csr_if.csr_addr;
  assign wr_data = cfg_we ? cfg_data : csr_if.csr_wdata;

  always @(posedge clk) begin
    if (wr_en) begin
      case (wr_addr)
        12'h300: mstatus_r <= wr_data;
        12'h305: mtvec_r   <= wr_data;
        12'h341: mepc_r    <= wr_data;
        12'h342: mcause_r  <= wr_data;
        12'h343: mtval_r   <= wr_data;
        default: ;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitCyc(input int target);
    while (cyc < target) tick();
  endtask

  task automatic setCsr(input logic [11:0] a, input logic [31:0] d);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic expWrite(input string n, input logic [11:0] a, input logic [31:0] d, input int cy);
    exp_t e;
    e.name = n; e.is_jump = 1'b0; e.addr = a; e.data = d; e.cyc = cy;
    sb.push_back(e);
  endtask

  task automatic expJump(input string n, input logic [31:0] target, input int cy);
    exp_t e;
    e.name = n; e.is_jump = 1'b1; e.addr = 12'h0; e.data = target; e.cyc = cy;
    sb.push_back(e);
  endtask

  // Drives one idex event (called just after a rising edge); returns the detect cycle.
  task automatic applyStimulus(input logic ec, input logic eb, input logic il, input logic mr,
                               input logic [31:0] inst, input logic [31:0] pc,
                               input logic [31:0] pcn, output int c);
    ecall_i    = ec;
    ebreak_i   = eb;
    illegal_i  = il;
    mret_i     = mr;
    inst_i     = inst;
    pc_i       = pc;
    pc_next_i  = pcn;
    hx_valid_i = 1'b1;
    c = cyc;
  endtask

  task automatic releaseStimulus();
    tick();
    ecall_i    = 1'b0;
    ebreak_i   = 1'b0;
    illegal_i  = 1'b0;
    mret_i     = 1'b0;
    hx_valid_i = 1'b0;
  endtask

  // Monitor: every accepted trap write or jump must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && ((csr_if.csr_we && !idex_csr_we_i) || jump_o)) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_event: we=%0b addr=0x%03h wdata=0x%08h jump=%0b jaddr=0x%08h, expected none",
                 csr_if.csr_we, csr_if.csr_addr, csr_if.csr_wdata, jump_o, jump_addr_o);
      end else begin
        mon_e = sb.pop_front();
        checkOutput({mon_e.name, "_kind"}, {31'h0, jump_o}, {31'h0, mon_e.is_jump});
        if (mon_e.is_jump) begin
          checkOutput({mon_e.name, "_target"}, jump_addr_o, mon_e.data);
        end else begin
          checkOutput({mon_e.name, "_addr"}, {20'h0, csr_if.csr_addr}, {20'h0, mon_e.addr});
          checkOutput({mon_e.name, "_data"}, csr_if.csr_wdata, mon_e.data);
        end
        checkOutput({mon_e.name, "_cycle"}, cyc, mon_e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int c;
    int cm;
    rst_n = 1'b0;
    ecall_i = 1'b0; ebreak_i = 1'b0; illegal_i = 1'b0; mret_i = 1'b0;
    inst_i = '0; pc_i = '0; pc_next_i = '0; hx_valid_i = 1'b0;
    ex_trap_i = 1'b0; tcmp_trap_i = 1'b0; soft_trap_i = 1'b0;
    idex_csr_we_i = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;

    @(negedge clk);
    checkOutput("rst_we",    {31'h0, csr_if.csr_we}, 32'h0);
    checkOutput("rst_addr",  {20'h0, csr_if.csr_addr}, 32'h0);
    checkOutput("rst_wdata", csr_if.csr_wdata, 32'h0);
    checkOutput("rst_jump",  {31'h0, jump_o}, 32'h0);
    checkOutput("rst_jaddr", jump_addr_o, 32'h0);
    checkOutput("rst_hold",  {31'h0, hold_o}, 32'h0);
    tick();
    rst_n = 1'b1;
    setCsr(12'h305, 32'h200);
    setCsr(12'h300, 32'h8);

    // ecall, direct mtvec: MIE=1 -> MPIE=1, MIE=0
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0073, 32'h100, 32'h104, c);
    expWrite("ecall_mepc",   12'h341, 32'h100, c + 1);
    expWrite("ecall_mcause", 12'h342, 32'd11,  c + 2);
    expWrite("ecall_mtval",  12'h343, 32'h0,   c + 3);
    expWrite("ecall_mstat",  12'h300, 32'h80,  c + 4);
    expJump ("ecall_jump",   32'h200,          c + 5);
    @(negedge clk);
    checkOutput("ecall_hold_detect", {31'h0, hold_o}, 32'h1);
    releaseStimulus();
    waitCyc(c + 5);
    @(negedge clk);
    checkOutput("ecall_hold_at_jump", {31'h0, hold_o}, 32'h1);
    waitCyc(c + 6);
    @(negedge clk);
    checkOutput("ecall_hold_after_jump", {31'h0, hold_o}, 32'h0);
    waitCyc(c + 7);

    // illegal instruction: mtval carries the instruction word
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h40, 32'h44, c);
    expWrite("ill_mepc",   12'h341, 32'h40,        c + 1);
    expWrite("ill_mcause", 12'h342, 32'd2,         c + 2);
    expWrite("ill_mtval",  12'h343, 32'hFFFF_FFFF, c + 3);
    expWrite("ill_mstat",  12'h300, 32'h0,         c + 4);
    expJump ("ill_jump",   32'h200,                c + 5);
    releaseStimulus();
    waitCyc(c + 7);

    // external + timer together: external wins, epc is pc_next
    setCsr(12'h300, 32'h8);
    ex_trap_i   = 1'b1;
    tcmp_trap_i = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h80, 32'h84, c);
    expWrite("ext_mepc",   12'h341, 32'h84,        c + 1);
    expWrite("ext_mcause", 12'h342, 32'h8000_000B, c + 2);
    expWrite("ext_mtval",  12'h343, 32'h0,         c + 3);
    expWrite("ext_mstat",  12'h300, 32'h80,        c + 4);
    expJump ("ext_jump",   32'h200,                c + 5);
    releaseStimulus();
    ex_trap_i = 1'b0;
    waitCyc(c + 7);

    // mret restores MIE from MPIE; pending timer is then taken
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h3020_0073, 32'h88, 32'h8C, cm);
    expWrite("mret_mstat", 12'h300, 32'h88, cm + 2);
    expJump ("mret_jump",  32'h84,          cm + 3);
    releaseStimulus();
    waitCyc(cm + 4);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h84, 32'h88, c);
    expWrite("tmr_mepc",   12'h341, 32'h88,        c + 1);
    expWrite("tmr_mcause", 12'h342, 32'h8000_0007, c + 2);
    expWrite("tmr_mtval",  12'h343, 32'h0,         c + 3);
    expWrite("tmr_mstat",  12'h300, 32'h80,        c + 4);
    expJump ("tmr_jump",   32'h200,                c + 5);
    releaseStimulus();
    tcmp_trap_i = 1'b0;
    waitCyc(c + 7);

    // vectored mtvec: interrupt is offset by cause*4, exception is not
    setCsr(12'h305, 32'h301);
    setCsr(12'h300, 32'h8);
    tcmp_trap_i = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h8C, 32'h90, c);
    expWrite("vtmr_mepc",   12'h341, 32'h90,        c + 1);
    expWrite("vtmr_mcause", 12'h342, 32'h8000_0007, c + 2);
    expWrite("vtmr_mtval",  12'h343, 32'h0,         c + 3);
    expWrite("vtmr_mstat",  12'h300, 32'h80,        c + 4);
    expJump ("vtmr_jump",   32'h31C,                c + 5);
    releaseStimulus();
    tcmp_trap_i = 1'b0;
    waitCyc(c + 7);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0073, 32'h60, 32'h64, c);
    expWrite("vec_mepc",   12'h341, 32'h60, c + 1);
    expWrite("vec_mcause", 12'h342, 32'd11, c + 2);
    expWrite("vec_mtval",  12'h343, 32'h0,  c + 3);
    expWrite("vec_mstat",  12'h300, 32'h0,  c + 4);
    expJump ("vec_jump",   32'h300,         c + 5);
    releaseStimulus();
    waitCyc(c + 7);

    // ebreak with idex CSR write colliding for two cycles in W_CAUSE
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0010_0073, 32'h44, 32'h48, c);
    expWrite("ebrk_mepc",   12'h341, 32'h44, c + 1);
    expWrite("ebrk_mcause", 12'h342, 32'd3,  c + 4);
    expWrite("ebrk_mtval",  12'h343, 32'h44, c + 5);
    expWrite("ebrk_mstat",  12'h300, 32'h0,  c + 6);
    expJump ("ebrk_jump",   32'h300,         c + 7);
    releaseStimulus();
    waitCyc(c + 2);
    idex_csr_we_i = 1'b1;
    waitCyc(c + 4);
    idex_csr_we_i = 1'b0;
    waitCyc(c + 9);

    // reset during W_TVAL aborts the sequence
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0073, 32'h10, 32'h14, c);
    expWrite("abort_mepc",   12'h341, 32'h10, c + 1);
    expWrite("abort_mcause", 12'h342, 32'd11, c + 2);
    releaseStimulus();
    waitCyc(c + 3);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("abort_we",    {31'h0, csr_if.csr_we}, 32'h0);
    checkOutput("abort_addr",  {20'h0, csr_if.csr_addr}, 32'h0);
    checkOutput("abort_wdata", csr_if.csr_wdata, 32'h0);
    checkOutput("abort_jump",  {31'h0, jump_o}, 32'h0);
    checkOutput("abort_hold",  {31'h0, hold_o}, 32'h0);
    waitCyc(c + 4);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("abort_idle_hold", {31'h0, hold_o}, 32'h0);
    checkOutput("abort_idle_addr", {20'h0, csr_if.csr_addr}, 32'h0);
    waitCyc(c + 6);

    // interrupt with MIE=0 is not taken
    ex_trap_i = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h20, 32'h24, c);
    @(negedge clk);
    checkOutput("nomie_hold", {31'h0, hold_o}, 32'h0);
    checkOutput("nomie_jump", {31'h0, jump_o}, 32'h0);
    releaseStimulus();
    @(negedge clk);
    checkOutput("nomie_hold_next", {31'h0, hold_o}, 32'h0);
    ex_trap_i = 1'b0;
    waitCyc(c + 8);

    checkOutput("sb_empty", sb.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
